mv_field_server: RTL and testbench

MV_FIELD_SERVER -- requirements
Module: mv_field_server

---
 rtl/mv_field_server.sv | 159 +++++++++++++++
 tb/tb_mv_field_server.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mv_field_server.sv
// Motion-vector field server: loads a raster field, serves filter reads and writebacks, drains results.
// Build option: define MV_SERVER_NULLFILL_EN to normalise NULL-flagged load words to 9'h100.
module mv_field_server #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 9
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [7:0]        width,
    input  logic [7:0]        height,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              rd_req,
    input  logic [15:0]       rd_index,
    output logic [DATA_W-1:0] rd_data,
    output logic              rise,
    input  logic              wr_sig,
    input  logic [7:0]        wr_x0,
    input  logic [7:0]        wr_y0,
    input  logic [7:0]        wr_data,
    output logic              nxt_block_sig,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              frame_done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] NULL_WORD = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, SERVE, DRAIN} state_t;
    state_t state_q;
    state_t state_d;

    logic [7:0]        w_q;
    logic [7:0]        h_q;
    logic [15:0]       n_q;
    logic [15:0]       lptr_q;
    logic [15:0]       rptr_q;
    logic [15:0]       wcnt_q;
    logic              rd_p1_q;
    logic              oob_p1_q;
    logic [DATA_W-1:0] fld_p1_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rise_q;
    logic              wr_sig_q;
    logic              wb_p1_q;
    logic              nxt_q;
    logic              out_valid_q;
    logic [7:0]        out_data_q;

    logic [DATA_W-1:0] field_mem  [DEPTH];
    logic [7:0]        result_mem [DEPTH];

    logic              load_fire;
    logic              rd_accept;
    logic              wr_edge;
    logic              wr_ok;
    logic [ADDR_W-1:0] wr_addr;
    logic              fetch;
    logic              beat;
    logic              last_beat;

    function automatic logic [DATA_W-1:0] store_word(input logic [DATA_W-1:0] d);
`ifdef MV_SERVER_NULLFILL_EN
        return d[DATA_W-1] ? NULL_WORD : d;
`else
        return d;
`endif
    endfunction

    always_comb begin
        load_fire = (state_q == LOAD) && load_valid && (n_q != 16'd0);
        // Engine is busy from capture until the cycle after rise, forcing the 1-cycle gap.
        rd_accept = (state_q == SERVE) && rd_req && !rd_p1_q && !rise_q;
        wr_edge   = (state_q == SERVE) && wr_sig && !wr_sig_q;
        wr_ok     = (wr_x0 != 8'd0) && (wr_y0 != 8'd0) && (wr_x0 <= w_q) && (wr_y0 <= h_q);
        wr_addr   = ADDR_W'(16'(wr_y0 - 8'd1) * 16'(w_q) + 16'(wr_x0) - 16'd1);
        fetch     = (state_q == DRAIN) && (rptr_q < n_q) && (!out_valid_q || out_ready);
        beat      = out_valid_q && out_ready;
        last_beat = (state_q == DRAIN) && beat && (rptr_q == n_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_valid) state_d = LOAD;
            LOAD: begin
                if (n_q == 16'd0)                               state_d = IDLE;
                else if (load_fire && (lptr_q == n_q - 16'd1))  state_d = SERVE;
            end
            SERVE:   if (wcnt_q == n_q) state_d = DRAIN;
            DRAIN:   if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            w_q         <= '0;
            h_q         <= '0;
            n_q         <= '0;
            lptr_q      <= '0;
            rptr_q      <= '0;
            wcnt_q      <= '0;
            rd_p1_q     <= 1'b0;
            oob_p1_q    <= 1'b0;
            rd_data_q   <= '0;
            rise_q      <= 1'b0;
            wr_sig_q    <= 1'b0;
            wb_p1_q     <= 1'b0;
            nxt_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && load_valid) begin
                w_q    <= width;
                h_q    <= height;
                n_q    <= 16'(width) * 16'(height);
                lptr_q <= '0;
                wcnt_q <= '0;
            end
            if (load_fire) lptr_q <= lptr_q + 16'd1;

            if (state_q != DRAIN) rptr_q <= '0;
            else if (fetch)       rptr_q <= rptr_q + 16'd1;

            rd_p1_q <= rd_accept;
            if (rd_accept) oob_p1_q <= (rd_index >= n_q);
            rise_q <= rd_p1_q;
            if (rd_p1_q) rd_data_q <= oob_p1_q ? NULL_WORD : fld_p1_q;

            wr_sig_q <= wr_sig;
            wb_p1_q  <= wr_edge;
            nxt_q    <= wb_p1_q;
            if (wr_edge && wr_ok) wcnt_q <= wcnt_q + 16'd1;

            // Output register refills on the same cycle it is consumed, so drain runs at full rate.
            if (fetch)     out_valid_q <= 1'b1;
            else if (beat) out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (load_fire)        field_mem[lptr_q[ADDR_W-1:0]] <= store_word(load_data);
        if (rd_accept)        fld_p1_q <= field_mem[rd_index[ADDR_W-1:0]];
        if (wr_edge && wr_ok) result_mem[wr_addr] <= wr_data;
        if (fetch)            out_data_q <= result_mem[rptr_q[ADDR_W-1:0]];
    end

    assign load_ready    = (state_q == LOAD);
    assign rd_data       = rd_data_q;
    assign rise          = rise_q;
    assign nxt_block_sig = nxt_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign frame_done    = last_beat;
endmodule

// File: tb/tb_mv_field_server.sv
// Randomised bench for mv_field_server against a frame-level reference model.
module tb_mv_field_server;
    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  width;
    logic [7:0]  height;
    logic        load_valid;
    logic [8:0]  load_data;
    logic        load_ready;
    logic        rd_req;
    logic [15:0] rd_index;
    logic [8:0]  rd_data;
    logic        rise;
    logic        wr_sig;
    logic [7:0]  wr_x0;
    logic [7:0]  wr_y0;
    logic [7:0]  wr_data;
    logic        nxt_block_sig;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        frame_done;

    mv_field_server dut (
        .CLK(CLK), .reset(reset), .width(width), .height(height),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .rd_req(rd_req), .rd_index(rd_index), .rd_data(rd_data), .rise(rise),
        .wr_sig(wr_sig), .wr_x0(wr_x0), .wr_y0(wr_y0), .wr_data(wr_data),
        .nxt_block_sig(nxt_block_sig), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int w_m, h_m, n_m, wcnt_m;
    logic [8:0] rd_last;
    logic [8:0] load_m   [0:4095];
    logic [8:0] field_m  [0:4095];
    logic [7:0] result_m [0:4095];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [8:0] store_m(input logic [8:0] d);
`ifdef MV_SERVER_NULLFILL_EN
        return d[8] ? 9'h100 : d;
`else
        return d;
`endif
    endfunction

    function automatic logic [8:0] rd_exp(input int idx);
        return (idx < n_m) ? field_m[idx] : 9'h100;
    endfunction

    task automatic model_write(input int x, input int y, input int d);
        if (x >= 1 && y >= 1 && x <= w_m && y <= h_m) begin
            result_m[(y - 1) * w_m + x - 1] = 8'(d);
            wcnt_m++;
        end
    endtask

    task automatic load_frame(input int w, input int h);
        int i;
        int guard;
        w_m = w; h_m = h; n_m = w * h; wcnt_m = 0;
        width = 8'(w); height = 8'(h);
        load_valid = 1'b1; load_data = load_m[0];
        tick();
        chk("load_ready_on", load_ready, 1);
        // Size inputs are only sampled at load start; scramble them from here on.
        width = 8'($urandom); height = 8'($urandom);
        i = 0; guard = 0;
        while (i < n_m && guard < 16 * n_m + 16) begin
            load_valid = ($urandom % 4 != 0);
            load_data  = load_m[i];
            tick();
            guard++;
            if (load_valid) begin
                field_m[i] = store_m(load_m[i]);
                i++;
            end
        end
        load_valid = 1'b0;
        chk("load_words", i, n_m);
        chk("load_ready_off", load_ready, 0);
    endtask

    // One SERVE operation starting this cycle: optional read pulse and/or writeback held for 'hold' cycles.
    task automatic serve_op(input bit do_rd, input int idx, input bit do_wr,
                            input int x, input int y, input int d, input int hold);
        logic [8:0] exp_rd;
        int last;
        chk("out_valid_serve", out_valid, 0);
        exp_rd = rd_exp(idx);
        last = (hold + 1 > 3) ? hold + 1 : 3;
        rd_req = do_rd; rd_index = 16'(idx);
        wr_sig = do_wr; wr_x0 = 8'(x); wr_y0 = 8'(y); wr_data = 8'(d);
        if (do_wr) model_write(x, y, d);
        for (int t = 1; t <= last; t++) begin
            tick();
            rd_req = 1'b0;
            if (t >= hold) wr_sig = 1'b0;
            chk("rise", rise, (do_rd && t == 2));
            chk("nxt_block_sig", nxt_block_sig, (do_wr && t == 2));
            if (t == 1) chk("rd_data_hold", rd_data, rd_last);
            if (do_rd && t >= 2) chk("rd_data", rd_data, exp_rd);
        end
        if (do_rd) rd_last = exp_rd;
    endtask

    task automatic drain(input bit alt);
        int beat;
        int guard;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        chk("drain_start", out_valid, 1);
        beat = 0; guard = 0;
        while (beat < n_m && guard < 8 * n_m + 20) begin
            out_ready = alt ? (guard % 2 == 0) : ($urandom % 3 != 0);
            #1;
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, result_m[beat]);
            if (out_ready) begin
                chk("frame_done", frame_done, (beat == n_m - 1));
                beat++;
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        #1;
        chk("drain_beats", beat, n_m);
        chk("out_valid_end", out_valid, 0);
        chk("frame_done_end", frame_done, 0);
        chk("load_ready_idle", load_ready, 0);
    endtask

    task automatic random_frame(input int w, input int h);
        int pos[$];
        int j, tmp, p, k;
        for (int i = 0; i < w * h; i++) load_m[i] = 9'($urandom);
        load_frame(w, h);
        pos.delete();
        for (int i = 0; i < n_m; i++) pos.push_back(i);
        for (int i = n_m - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = pos[i]; pos[i] = pos[j]; pos[j] = tmp;
        end
        for (int i = 0; i < n_m; i++) begin
            if ($urandom % 3 == 0) begin
                k = $urandom % 4;
                case (k)
                    0:       serve_op($urandom % 2, $urandom_range(n_m + 3, 0), 1, 0, 1, $urandom, 1);
                    1:       serve_op($urandom % 2, $urandom_range(n_m + 3, 0), 1, 1, 0, $urandom, 1);
                    2:       serve_op($urandom % 2, $urandom_range(n_m + 3, 0), 1, w + 1, 1, $urandom, 2);
                    default: serve_op($urandom % 2, $urandom_range(n_m + 3, 0), 1, 1, h + 1, $urandom, 1);
                endcase
            end
            if ($urandom % 3 == 0) serve_op(1, $urandom_range(n_m + 3, 0), 0, 0, 0, 0, 1);
            p = pos[i];
            serve_op($urandom % 2, $urandom_range(n_m + 3, 0), 1, p % w + 1, p / w + 1,
                     $urandom, $urandom_range(3, 1));
        end
        chk("wcnt_model", wcnt_m, n_m);
        drain(0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; width = '0; height = '0; load_valid = 1'b0; load_data = '0;
        rd_req = 1'b0; rd_index = '0; wr_sig = 1'b0; wr_x0 = '0; wr_y0 = '0; wr_data = '0;
        out_ready = 1'b0; rd_last = '0;
        tick();
        tick();
        chk("rst_load_ready", load_ready, 0);
        chk("rst_rise", rise, 0);
        chk("rst_nxt", nxt_block_sig, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        tick();

        // Directed 3x2 frame
        for (int i = 0; i < 6; i++) load_m[i] = 9'(5 + i);
        load_frame(3, 2);
        serve_op(1, 4, 0, 0, 0, 0, 1);
        chk("read_idx4", rd_data, 9'h009);
        serve_op(1, 6, 0, 0, 0, 0, 1);
        chk("read_idx6_null", rd_data, 9'h100);
        rd_req = 1'b1; rd_index = 16'd6;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("rise_held", rise, (t % 3 == 2));
            if (t % 3 == 2) chk("rd_data_held", rd_data, 9'h100);
        end
        rd_req = 1'b0;
        tick();
        chk("rise_held_end", rise, 0);
        serve_op(0, 0, 1, 2, 2, 8'h33, 5);
        serve_op(0, 0, 1, 4, 1, 8'h44, 1);
        chk("wcnt_after_discard", wcnt_m, 1);
        serve_op(1, 2, 1, 1, 1, 8'h10, 1);
        serve_op(0, 0, 1, 2, 1, 8'h11, 1);
        serve_op(1, 0, 1, 3, 1, 8'h12, 2);
        serve_op(0, 0, 1, 1, 2, 8'h13, 1);
        serve_op(0, 0, 1, 3, 2, 8'h15, 1);
        chk("result4", result_m[4], 8'h33);
        drain(1);

        // Randomised frames
        for (int f = 0; f < 3; f++) random_frame($urandom_range(6, 1), $urandom_range(5, 1));

        // Zero-size frame returns to IDLE; SERVE-only ports are ignored there
        width = 8'd0; height = 8'd5; load_valid = 1'b1;
        tick();
        chk("n0_load_ready", load_ready, 1);
        load_valid = 1'b0;
        tick();
        chk("n0_idle", load_ready, 0);
        rd_req = 1'b1; rd_index = 16'd0; wr_sig = 1'b1; wr_x0 = 8'd1; wr_y0 = 8'd1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("idle_rise", rise, 0);
            chk("idle_nxt", nxt_block_sig, 0);
            wr_sig = 1'b0;
        end
        rd_req = 1'b0;
        tick();

        // Reset mid-SERVE with a read in flight
        for (int i = 0; i < 4; i++) load_m[i] = 9'($urandom);
        load_frame(2, 2);
        rd_req = 1'b1; rd_index = 16'd1;
        tick();
        rd_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_rise", rise, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_load_ready", load_ready, 0);
        chk("mid_rst_nxt", nxt_block_sig, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        tick();
        chk("mid_rst_rise2", rise, 0);
        reset = 1'b0;
        rd_last = '0;
        tick();
        chk("post_rst_rise", rise, 0);
        chk("post_rst_idle", load_ready, 0);
        random_frame(2, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
